// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: sweeps the command_lookup character buffer and mirrors it onto an
// HD44780-compatible 2x16 LCD (8-bit, write-only). It runs the power-on init sequence,
// then repeatedly writes the DDRAM address commands and the characters of each frame.
//
// Handshake: there is no valid/ready pair on this block. buffer_ready is a level
// qualifier sampled in IDLE (start a frame) and at the end of every byte write
// (continue or abort). data_in is treated as valid LOOKUP_LAT cycles after sel
// changes and is sampled only in the FETCH capture cycle.
module lcd_refresh_ctrl #(
    parameter int unsigned NUM_CHARS      = 32,
    parameter int unsigned CHARS_PER_LINE = 16,
    parameter int unsigned LOOKUP_LAT     = 1,
    parameter int unsigned PWR_ON_CYCLES  = 1500000,
    parameter int unsigned E_PULSE_CYCLES = 50,
    parameter int unsigned CMD_CYCLES     = 4000,
    parameter int unsigned CLEAR_CYCLES   = 160000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buffer_ready,
    input  logic [7:0] data_in,
    output logic [5:0] sel,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       init_done,
    output logic       frame_done
);

    // Top-level sequencing states
    localparam logic [2:0] S_PWR_WAIT = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_ADDR     = 3'd3;
    localparam logic [2:0] S_FETCH    = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;

    // Phases of a single byte write on the LCD bus
    localparam logic [1:0] WP_SETUP = 2'd0;
    localparam logic [1:0] WP_EHIGH = 2'd1;
    localparam logic [1:0] WP_HOLD  = 2'd2;
    localparam logic [1:0] WP_WAIT  = 2'd3;

    localparam logic [5:0]  LAST_IDX  = 6'(NUM_CHARS - 1);
    localparam logic [5:0]  LINE2_IDX = 6'(CHARS_PER_LINE);
    localparam logic [31:0] PWR_LAST  = 32'(PWR_ON_CYCLES - 1);
    localparam logic [31:0] E_LAST    = 32'(E_PULSE_CYCLES - 1);
    localparam logic [31:0] CMD_LAST  = 32'(CMD_CYCLES - 1);
    localparam logic [31:0] CLR_LAST  = 32'(CLEAR_CYCLES - 1);
    localparam logic [31:0] LAT_LAST  = 32'(LOOKUP_LAT);

    logic [2:0]  state, state_n;
    logic [1:0]  init_step, init_step_n;
    logic [5:0]  idx, idx_n;
    logic [31:0] cnt, cnt_n;
    logic [5:0]  sel_n;
    logic        rs_n;
    logic [7:0]  db_n;
    logic        init_done_n;
    logic        frame_done_n;
    logic        start;

    logic        wr_busy;
    logic [1:0]  wr_phase;
    logic [31:0] wr_cnt;
    logic        wr_clear;
    logic        wr_done;
    logic [31:0] wait_last;

    // Init command bytes in issue order: function set, display on, entry mode, clear
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Non-printable characters are shown as a space
    function automatic logic [7:0] printable(input logic [7:0] c);
        printable = (c < 8'h20 || c > 8'h7E) ? 8'h20 : c;
    endfunction

    assign lcd_rw    = 1'b0;
    assign wait_last = wr_clear ? CLR_LAST : CMD_LAST;
    // Last cycle of the post-write wait; the sequencer may launch the next byte here
    assign wr_done   = wr_busy && (wr_phase == WP_WAIT) && (wr_cnt == wait_last);

    // Byte write engine: SETUP -> E high -> HOLD -> settle wait, restartable back-to-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_busy  <= 1'b0;
            wr_phase <= WP_SETUP;
            wr_cnt   <= '0;
            wr_clear <= 1'b0;
            lcd_e    <= 1'b0;
        end else if (start) begin
            wr_busy  <= 1'b1;
            wr_phase <= WP_SETUP;
            wr_cnt   <= '0;
            wr_clear <= !rs_n && (db_n == 8'h01);
            lcd_e    <= 1'b0;
        end else if (wr_busy) begin
            case (wr_phase)
                WP_SETUP: begin
                    wr_phase <= WP_EHIGH;
                    wr_cnt   <= '0;
                    lcd_e    <= 1'b1;
                end
                WP_EHIGH: begin
                    if (wr_cnt == E_LAST) begin
                        wr_phase <= WP_HOLD;
                        lcd_e    <= 1'b0;
                    end else begin
                        wr_cnt <= wr_cnt + 32'd1;
                    end
                end
                WP_HOLD: begin
                    wr_phase <= WP_WAIT;
                    wr_cnt   <= '0;
                end
                default: begin
                    if (wr_done) wr_busy <= 1'b0;
                    else         wr_cnt  <= wr_cnt + 32'd1;
                end
            endcase
        end
    end

    // Sequencer next-state: init, address commands, fetch and character writes.
    // lcd_db doubles as the captured character register (already sanitised).
    always_comb begin
        state_n      = state;
        init_step_n  = init_step;
        idx_n        = idx;
        cnt_n        = cnt;
        sel_n        = sel;
        rs_n         = lcd_rs;
        db_n         = lcd_db;
        init_done_n  = init_done;
        frame_done_n = 1'b0;
        start        = 1'b0;
        case (state)
            S_PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_n     = S_INIT;
                    cnt_n       = '0;
                    init_step_n = 2'd0;
                    start       = 1'b1;
                    rs_n        = 1'b0;
                    db_n        = init_cmd(2'd0);
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_INIT: begin
                if (wr_done) begin
                    if (init_step == 2'd3) begin
                        init_done_n = 1'b1;
                        state_n     = S_IDLE;
                    end else begin
                        init_step_n = init_step + 2'd1;
                        start       = 1'b1;
                        rs_n        = 1'b0;
                        db_n        = init_cmd(init_step + 2'd1);
                    end
                end
            end
            S_IDLE: begin
                sel_n = '0;
                if (buffer_ready) begin
                    state_n = S_ADDR;
                    idx_n   = '0;
                    start   = 1'b1;
                    rs_n    = 1'b0;
                    db_n    = 8'h80;
                end
            end
            S_ADDR: begin
                if (wr_done) begin
                    if (!buffer_ready) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_FETCH;
                        sel_n   = idx;
                        cnt_n   = '0;
                    end
                end
            end
            S_FETCH: begin
                if (!buffer_ready) begin
                    state_n = S_IDLE;
                end else if (cnt == LAT_LAST) begin
                    state_n = S_WRITE;
                    start   = 1'b1;
                    rs_n    = 1'b1;
                    db_n    = printable(data_in);
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_WRITE: begin
                if (wr_done) begin
                    if (!buffer_ready) begin
                        state_n = S_IDLE;
                    end else if (idx == LAST_IDX) begin
                        frame_done_n = 1'b1;
                        state_n      = S_IDLE;
                    end else begin
                        idx_n = idx + 6'd1;
                        if (idx + 6'd1 == LINE2_IDX) begin
                            state_n = S_ADDR;
                            start   = 1'b1;
                            rs_n    = 1'b0;
                            db_n    = 8'hC0;
                        end else begin
                            state_n = S_FETCH;
                            sel_n   = idx + 6'd1;
                            cnt_n   = '0;
                        end
                    end
                end
            end
            default: state_n = S_PWR_WAIT;
        endcase
    end

    // Sequencer registers; async reset aborts any write in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_PWR_WAIT;
            init_step  <= 2'd0;
            idx        <= '0;
            cnt        <= '0;
            sel        <= '0;
            lcd_rs     <= 1'b0;
            lcd_db     <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            init_step  <= init_step_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            lcd_rs     <= rs_n;
            lcd_db     <= db_n;
            init_done  <= init_done_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Testbench for lcd_refresh_ctrl with small timing parameters. A bus monitor decodes every
// E strobe into {rs, db} and checks it against an expected queue built from the frame
// contents (address commands at line starts, non-printables shown as spaces).
module tb_lcd_refresh_ctrl;

  localparam int NUM   = 4;
  localparam int CPL   = 2;
  localparam int PWR   = 20;
  localparam int EP    = 2;
  localparam int CMD   = 4;
  localparam int CLEAR = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       buffer_ready = 1'b0;
  logic [7:0] data_in;
  logic [5:0] sel;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_db_unused;
  logic [7:0] lcd_db;
  logic       init_done, frame_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_refresh_ctrl #(
    .NUM_CHARS(NUM), .CHARS_PER_LINE(CPL), .LOOKUP_LAT(1), .PWR_ON_CYCLES(PWR),
    .E_PULSE_CYCLES(EP), .CMD_CYCLES(CMD), .CLEAR_CYCLES(CLEAR)
  ) dut (
    .clk(clk), .rst(rst), .buffer_ready(buffer_ready), .data_in(data_in), .sel(sel),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .init_done(init_done), .frame_done(frame_done)
  );

  // character buffer model: one-cycle registered lookup; junk while E is high
  logic [7:0] mem [NUM];
  logic [7:0] lookup_q;
  logic [7:0] junk = 8'h00;
  always @(posedge clk) lookup_q <= mem[sel[1:0]];
  always @(negedge clk) junk = 8'($urandom);
  assign data_in = lcd_e ? junk : lookup_q;
  assign lcd_db_unused = 1'b0;

  // scoreboard
  logic [8:0] exp_q[$];
  logic [5:0] sel_q[$];
  int rise_log[$];
  int fall_log[$];
  int id_cyc = -1;
  int fd_count = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] model_char(input logic [7:0] c);
    return (c >= 8'h20 && c <= 8'h7E) ? c : 8'h20;
  endfunction

  // bus monitor
  logic e_prev = 1'b0, fd_prev = 1'b0, id_prev = 1'b0;
  int rise_cyc = 0;
  logic rise_rs;
  logic [7:0] rise_db;
  always @(negedge clk) begin
    if (rst) begin
      e_prev = 1'b0; fd_prev = 1'b0; id_prev = 1'b0;
    end else begin
      if (lcd_e && !e_prev) begin
        rise_cyc = cyc; rise_rs = lcd_rs; rise_db = lcd_db;
        rise_log.push_back(cyc);
        chk("rw_low", lcd_rw, 0);
        if (lcd_rs) begin
          if (sel_q.size() == 0) chk("unexpected_data_sel", sel, 63);
          else chk("sel_idx", sel, sel_q.pop_front());
        end
      end
      if (lcd_e && e_prev) chk("bus_stable", {lcd_rs, lcd_db}, {rise_rs, rise_db});
      if (!lcd_e && e_prev) begin
        fall_log.push_back(cyc);
        chk("e_width", cyc - rise_cyc, EP);
        if (exp_q.size() == 0) chk("unexpected_write", {rise_rs, rise_db}, 9'h1FF);
        else chk("bus_byte", {rise_rs, rise_db}, exp_q.pop_front());
      end
      if (sel > 6'(NUM - 1)) chk("sel_range", sel, NUM - 1);
      if (frame_done) begin
        fd_count++;
        if (fd_prev) chk("frame_done_width", 2, 1);
      end
      if (init_done && !id_prev) id_cyc = cyc;
      e_prev = lcd_e; fd_prev = frame_done; id_prev = init_done;
    end
  end

  // driver tasks
  task automatic load_mem(input logic [31:0] chars);
    for (int i = 0; i < NUM; i++) mem[i] = chars[8*i +: 8];
  endtask

  task automatic push_frame(input logic [31:0] expb);
    for (int i = 0; i < NUM; i++) begin
      if (i == 0)   exp_q.push_back({1'b0, 8'h80});
      if (i == CPL) exp_q.push_back({1'b0, 8'hC0});
      exp_q.push_back({1'b1, expb[8*i +: 8]});
      sel_q.push_back(6'(i));
    end
  endtask

  function automatic logic [31:0] model_frame(input logic [31:0] chars);
    logic [31:0] r;
    for (int i = 0; i < NUM; i++) r[8*i +: 8] = model_char(chars[8*i +: 8]);
    return r;
  endfunction

  task automatic check_outputs_reset(input string tag);
    chk({tag, "_e"}, lcd_e, 0);
    chk({tag, "_rs"}, lcd_rs, 0);
    chk({tag, "_db"}, lcd_db, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_rw"}, lcd_rw, 0);
  endtask

  // releases reset and checks the whole init sequence and its timing
  task automatic init_check();
    int rel, n;
    exp_q.delete(); sel_q.delete(); rise_log.delete(); fall_log.delete();
    id_cyc = -1;
    exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06}); exp_q.push_back({1'b0, 8'h01});
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    n = 0;
    while (!init_done && n < 400) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("init_done_rise", init_done, 1);
    chk("init_write_count", rise_log.size(), 4);
    chk("init_queue_empty", exp_q.size(), 0);
    if (rise_log.size() >= 4 && fall_log.size() >= 4) begin
      chk("pwr_on_wait", rise_log[0] - rel, PWR + 1);
      for (int i = 0; i < 3; i++) chk("init_byte_period", rise_log[i+1] - rise_log[i], 2 + EP + CMD);
      chk("clear_wait", id_cyc - fall_log[3], 1 + CLEAR);
    end
  endtask

  task automatic run_frame(input logic [31:0] chars, input logic [31:0] expb, input int nframes);
    int seen, n, fd0;
    load_mem(chars);
    for (int f = 0; f < nframes; f++) push_frame(expb);
    fd0 = fd_count;
    seen = 0; n = 0;
    buffer_ready = 1'b1;
    while (seen < nframes && n < 3000) begin
      @(negedge clk); n++;
      if (frame_done) seen++;
    end
    buffer_ready = 1'b0;
    chk("frame_timeout", seen, nframes);
    repeat (20) @(negedge clk);
    chk("frame_queue_empty", exp_q.size(), 0);
    chk("frame_sel_queue_empty", sel_q.size(), 0);
    chk("frame_done_count", fd_count - fd0, nframes);
    chk("idle_sel_zero", sel, 0);
  endtask

  typedef struct {
    logic [31:0] chars;
    logic [31:0] expb;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [31:0] rc;
    int n, fd0;
    vecs[0] = '{32'h4405_4241, 32'h4420_4241};
    vecs[1] = '{32'h7F7E_201F, 32'h207E_2020};
    vecs[2] = '{32'h8061_FF00, 32'h2061_2020};
    vecs[3] = '{32'h3332_3130, 32'h3332_3130};
    load_mem(32'h0);

    // power-on reset and init
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_reset("por");
    init_check();

    // table-driven frames
    for (int v = 0; v < 4; v++) run_frame(vecs[v].chars, vecs[v].expb, 1);

    // random frames against the model
    for (int r = 0; r < 3; r++) begin
      rc = $urandom;
      run_frame(rc, model_frame(rc), 1);
    end

    // drop buffer_ready during the write of idx 1
    load_mem(vecs[0].chars);
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, model_char(mem[0])});
    exp_q.push_back({1'b1, model_char(mem[1])});
    sel_q.push_back(6'd0); sel_q.push_back(6'd1);
    fd0 = fd_count;
    buffer_ready = 1'b1;
    n = 0;
    while (!(lcd_e && lcd_rs && sel == 6'd1) && n < 500) begin @(negedge clk); n++; end
    chk("drop_reached_idx1", sel, 1);
    buffer_ready = 1'b0;
    repeat (40) @(negedge clk);
    chk("drop_queue_empty", exp_q.size(), 0);
    chk("drop_no_frame_done", fd_count - fd0, 0);
    chk("drop_idle_sel", sel, 0);
    run_frame(vecs[2].chars, vecs[2].expb, 1);

    // async reset during E high of a data write
    load_mem(vecs[3].chars);
    push_frame(vecs[3].expb);
    buffer_ready = 1'b1;
    n = 0;
    while (!(lcd_e && lcd_rs) && n < 500) begin @(negedge clk); n++; end
    chk("rst_during_e_reached", lcd_e, 1);
    #2 rst = 1'b1;
    #1 check_outputs_reset("midwrite_rst");
    buffer_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_reset("rst_hold");
    init_check();
    run_frame(vecs[1].chars, vecs[1].expb, 1);

    // back-to-back frames with buffer_ready held high
    rc = $urandom;
    run_frame(rc, model_frame(rc), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
